// File: rtl/cpu_halt_dumper.sv
// cpu_halt_dumper
//
// Watches the CPU halt flag and an optional watchdog. On the first halt edge
// or watchdog expiry it freezes a snapshot of the register file and the cycle
// counter, then streams the snapshot as a byte frame over a valid/ready port:
//   0xA5, status, count (MSB first), reg 0 .. reg NUM_REGS-1 (each MSB first),
//   checksum (sum mod 256 of every preceding byte, header included).
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high; aborts any frame in progress
//   cpu_halted   CPU halt flag (level); its rising edge triggers the dump
//   regs_flat    register file, reg i at [i*REG_W +: REG_W]
//   out_data     frame byte
//   out_valid    out_data holds a frame byte
//   out_ready    sink accepts the byte this cycle
//   done         whole frame accepted (sticky until reset)
//   timed_out    snapshot was caused by the watchdog (sticky until reset)
//   cycle_count  live cycle counter; frozen at the captured value once triggered
//
// Handshake: a byte transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data holds its value; the next byte appears the cycle after acceptance.
// out_valid never drops until the byte it qualifies has been accepted.

module cpu_halt_dumper #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 8,
    parameter int CYC_W    = 32,
    parameter int TIMEOUT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_halted,
    input  logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      done,
    output logic                      timed_out,
    output logic [CYC_W-1:0]          cycle_count
);

    localparam int CYC_B     = CYC_W / 8;
    localparam int REG_B     = REG_W / 8;
    // Payload = status + count + registers; header and checksum are added
    // around it.
    localparam int PAY_B     = 1 + CYC_B + NUM_REGS * REG_B;
    localparam int FRAME_LEN = PAY_B + 2;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] PRE_LAST    = IDX_W'(FRAME_LEN - 2);
    localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    logic                      halted_q;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                csum;
    // Snapshot held as a shift register: the top byte is always the next
    // payload byte to present.
    logic [PAY_B*8-1:0]        shift_q;

    logic                      halt_evt;
    logic                      tmo_evt;
    logic [7:0]                status_now;
    logic [NUM_REGS*REG_W-1:0] regs_ordered;
    logic [PAY_B*8-1:0]        payload;

    always_comb begin
        halt_evt   = cpu_halted & ~halted_q;
        tmo_evt    = (TIMEOUT != 0) && (cycle_count == TIMEOUT_VAL);
        // Halt wins when both events land in the same cycle.
        status_now = halt_evt ? 8'h01 : 8'h02;
        // Reverse register order so reg 0 ends up in the most significant
        // slot and is shifted out first.
        regs_ordered = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_ordered[(NUM_REGS-1-i)*REG_W +: REG_W] = regs_flat[i*REG_W +: REG_W];
        end
        payload = {status_now, cycle_count, regs_ordered};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            cycle_count <= '0;
            halted_q    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            idx         <= '0;
            csum        <= 8'h00;
            shift_q     <= '0;
        end else begin
            halted_q <= cpu_halted;
            case (state)
                S_RUN: begin
                    if (halt_evt || tmo_evt) begin
                        // Counter is not incremented here, so it freezes at
                        // exactly the captured value.
                        state     <= S_SEND;
                        out_valid <= 1'b1;
                        out_data  <= 8'hA5;
                        shift_q   <= payload;
                        idx       <= '0;
                        csum      <= 8'h00;
                        timed_out <= ~halt_evt;
                    end else if (cycle_count != {CYC_W{1'b1}}) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        csum <= csum + out_data;
                        if (idx == LAST_IDX) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (idx == PRE_LAST) begin
                                // Fold in the byte being accepted now so the
                                // checksum is ready without a bubble.
                                out_data <= csum + out_data;
                            end else begin
                                out_data <= shift_q[PAY_B*8-1 -: 8];
                                shift_q  <= shift_q << 8;
                            end
                        end
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_halt_dumper.sv
// Bench for cpu_halt_dumper: three instances (defaults, watchdog of 20,
// widened 4x16-bit registers with a 16-bit counter) share the inputs; a
// selector routes the instance under test onto the monitor signals.

module tb_cpu_halt_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        rdy;
    logic [63:0] regs;

    logic [7:0]  d0_data, d1_data, d2_data;
    logic        d0_valid, d1_valid, d2_valid;
    logic        d0_done, d1_done, d2_done;
    logic        d0_tmo, d1_tmo, d2_tmo;
    logic [31:0] d0_count, d1_count;
    logic [15:0] d2_count;

    logic [7:0]  mon_data;
    logic        mon_valid, mon_done, mon_tmo;
    logic [31:0] mon_count;
    int          sel;

    typedef struct {
        logic ready;
        logic exp_valid;
        int   exp_idx;
        logic exp_done;
    } vec_t;
    vec_t vec[19];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    always #5 clk = ~clk;

    cpu_halt_dumper u_d0 (
        .clk(clk), .reset(rst), .cpu_halted(halt), .regs_flat(regs),
        .out_data(d0_data), .out_valid(d0_valid), .out_ready(rdy),
        .done(d0_done), .timed_out(d0_tmo), .cycle_count(d0_count)
    );

    cpu_halt_dumper #(.TIMEOUT(20)) u_d1 (
        .clk(clk), .reset(rst), .cpu_halted(halt), .regs_flat(regs),
        .out_data(d1_data), .out_valid(d1_valid), .out_ready(rdy),
        .done(d1_done), .timed_out(d1_tmo), .cycle_count(d1_count)
    );

    cpu_halt_dumper #(.NUM_REGS(4), .REG_W(16), .CYC_W(16)) u_d2 (
        .clk(clk), .reset(rst), .cpu_halted(halt), .regs_flat(regs),
        .out_data(d2_data), .out_valid(d2_valid), .out_ready(rdy),
        .done(d2_done), .timed_out(d2_tmo), .cycle_count(d2_count)
    );

    always_comb begin
        mon_data  = d0_data;
        mon_valid = d0_valid;
        mon_done  = d0_done;
        mon_tmo   = d0_tmo;
        mon_count = d0_count;
        if (sel == 1) begin
            mon_data  = d1_data;
            mon_valid = d1_valid;
            mon_done  = d1_done;
            mon_tmo   = d1_tmo;
            mon_count = d1_count;
        end else if (sel == 2) begin
            mon_data  = d2_data;
            mon_valid = d2_valid;
            mon_done  = d2_done;
            mon_tmo   = d2_tmo;
            mon_count = {16'h0000, d2_count};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_count(input logic [31:0] v);
        int n = 0;
        while (mon_count != v && n < 2000) begin
            tick();
            n++;
        end
        check("wait_count", mon_count, v);
    endtask

    // Expected frame from the bench's own model of the byte layout.
    task automatic build_exp(input logic [7:0] st, input logic [31:0] cnt, input int cb,
                             input logic [63:0] r, input int nregs, input int rb);
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(st);
        for (int j = cb - 1; j >= 0; j--) exp_q.push_back(cnt[j*8 +: 8]);
        for (int k = 0; k < nregs; k++)
            for (int b = rb - 1; b >= 0; b--) exp_q.push_back(r[(k*rb+b)*8 +: 8]);
        sum = 8'h00;
        foreach (exp_q[i]) sum = sum + exp_q[i];
        exp_q.push_back(sum);
    endtask

    // rdy is held high; every sampled valid byte is accepted on the next edge.
    task automatic collect(input int n, input int max_cyc);
        int cyc = 0;
        got_q.delete();
        while (got_q.size() < n && cyc < max_cyc) begin
            if (mon_valid) got_q.push_back(mon_data);
            tick();
            cyc++;
        end
        check("collect_bytes", got_q.size(), n);
    endtask

    task automatic compare_frame(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Backpressure table: ready drops for 3 cycles while byte 5 is shown.
        for (int i = 0; i < 5; i++) vec[i] = '{1'b1, 1'b1, i, 1'b0};
        vec[5] = '{1'b0, 1'b1, 5, 1'b0};
        vec[6] = '{1'b0, 1'b1, 5, 1'b0};
        vec[7] = '{1'b0, 1'b1, 5, 1'b0};
        vec[8] = '{1'b1, 1'b1, 5, 1'b0};
        for (int i = 9; i < 18; i++) vec[i] = '{1'b1, 1'b1, i - 3, 1'b0};
        vec[18] = '{1'b1, 1'b0, 0, 1'b1};

        sel  = 0;
        rst  = 1'b1;
        halt = 1'b0;
        rdy  = 1'b1;
        for (int i = 0; i < 8; i++) regs[i*8 +: 8] = 8'(17 * (i + 1));
        tick();
        tick();

        // Reset state
        check("rst_valid", d0_valid, 1'b0);
        check("rst_data", d0_data, 8'h00);
        check("rst_done", d0_done, 1'b0);
        check("rst_tmo", d0_tmo, 1'b0);
        check("rst_count", d0_count, 32'd0);
        check("rst_valid_d2", d2_valid, 1'b0);
        rst = 1'b0;

        // Halt at count 0x64, defaults
        wait_count(32'h64);
        halt = 1'b1;
        build_exp(8'h01, 32'h64, 4, regs, 8, 1);
        collect(15, 60);
        compare_frame("halt");
        check("halt_done", mon_done, 1'b1);
        check("halt_valid_off", mon_valid, 1'b0);
        check("halt_tmo", mon_tmo, 1'b0);
        check("halt_count_frozen", mon_count, 32'h64);

        // Flag already high out of reset, then backpressure on byte 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        build_exp(8'h01, 32'h0, 4, regs, 8, 1);
        tick();
        for (int i = 0; i < 19; i++) begin
            check($sformatf("bp_valid%0d", i), mon_valid, vec[i].exp_valid);
            if (vec[i].exp_valid)
                check($sformatf("bp_data%0d", i), mon_data, exp_q[vec[i].exp_idx]);
            check($sformatf("bp_done%0d", i), mon_done, vec[i].exp_done);
            rdy = vec[i].ready;
            tick();
        end
        rdy = 1'b1;

        // Reset mid-frame after byte 7, then a fresh frame
        rst  = 1'b1;
        halt = 1'b0;
        tick();
        rst = 1'b0;
        wait_count(32'h20);
        halt = 1'b1;
        collect(8, 40);
        rst = 1'b1;
        tick();
        check("abort_valid", mon_valid, 1'b0);
        check("abort_count", mon_count, 32'd0);
        check("abort_done", mon_done, 1'b0);
        check("abort_data", mon_data, 8'h00);
        halt = 1'b0;
        tick();
        rst = 1'b0;
        wait_count(32'h10);
        halt = 1'b1;
        build_exp(8'h01, 32'h10, 4, regs, 8, 1);
        collect(15, 60);
        compare_frame("fresh");
        check("fresh_done", mon_done, 1'b1);

        // Watchdog only
        sel  = 1;
        rst  = 1'b1;
        halt = 1'b0;
        tick();
        rst = 1'b0;
        build_exp(8'h02, 32'd20, 4, regs, 8, 1);
        collect(15, 100);
        compare_frame("wdog");
        check("wdog_tmo", mon_tmo, 1'b1);
        check("wdog_done", mon_done, 1'b1);

        // Halt edge and watchdog in the same cycle: halt wins
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_count(32'd20);
        halt = 1'b1;
        build_exp(8'h01, 32'd20, 4, regs, 8, 1);
        collect(15, 60);
        compare_frame("simul");
        check("simul_tmo", mon_tmo, 1'b0);

        // Widened registers and counter; later halt edge ignored in DONE
        sel  = 2;
        regs = {16'h8001, 16'h0F0E, 16'hABCD, 16'h1234};
        rst  = 1'b1;
        halt = 1'b0;
        tick();
        rst = 1'b0;
        wait_count(32'h30);
        halt = 1'b1;
        build_exp(8'h01, 32'h30, 2, regs, 4, 2);
        collect(13, 60);
        compare_frame("wide");
        check("wide_done", mon_done, 1'b1);
        halt = 1'b0;
        tick();
        tick();
        halt = 1'b1;
        tick();
        tick();
        tick();
        check("wide_rehalt_valid", mon_valid, 1'b0);
        check("wide_rehalt_done", mon_done, 1'b1);
        check("wide_rehalt_count", mon_count, 32'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
